keypad_scanner: RTL and testbench

//  Input-side counterpart of the 7-seg/LED display path: scans a 4x4 matrix keypad and debounces it.

---
 rtl/keypad_scanner_if.sv | 38 +++
 rtl/keypad_scanner.sv | 196 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - CPU-side entry-word handshake between keypad scanner and its reader
//
// Purpose: bundles the key/entry-word outputs and the read acknowledge.
// Signals:
//   key_valid   one-cycle pulse when a new debounced key is accepted
//   key_code    {row_idx, col_idx} of the last accepted key
//   value       16-bit entry word, newest key in the low nibble
//   data_ready  word holds an unread key; cleared by rd_ack
//   overflow    sticky: a key arrived while data_ready was still set
//   rd_ack      reader consumed value (driven by the reader)
// Modports: master = scanner side, slave = reader side.

interface keypad_scanner_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] value;
    logic        data_ready;
    logic        overflow;
    logic        rd_ack;

    modport master (
        output key_valid,
        output key_code,
        output value,
        output data_ready,
        output overflow,
        input  rd_ack
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  value,
        input  data_ready,
        input  overflow,
        output rd_ack
    );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and hex entry word
//
// Purpose: drives keypad columns one-cold, synchronises and debounces the
// active-low rows, and shifts each accepted key code into a 16-bit entry word
// handed to the reader with a data_ready/rd_ack handshake.
// Ports:
//   sys_clk   board clock, all state on rising edge
//   reset     asynchronous, active-low
//   row_in    keypad rows, active-low, asynchronous to sys_clk
//   col_out   keypad column drive, one-cold
//   cpu       keypad_scanner_if.master (key_valid, key_code, value,
//             data_ready, overflow out; rd_ack in)
// Parameters:
//   SCAN_DIV        sys_clk cycles per column dwell (>= 4)
//   DEBOUNCE_SCANS  consecutive matching dwell samples for press and release

module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    keypad_scanner_if.master cpu
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED
    } state_t;

    state_t          state, state_d;
    logic [3:0]      col_q, col_d;
    logic [3:0]      cand_q, cand_d;
    logic [CW-1:0]   deb_cnt, deb_d;
    logic            accept;
    logic [3:0]      code_d;

    logic [3:0]      row_meta;
    logic [3:0]      rows_s;
    logic [DW-1:0]   dwell_cnt;
    logic            sample;

    logic            key_valid_q;
    logic [3:0]      key_code_q;
    logic [15:0]     value_q;
    logic            data_ready_q;
    logic            overflow_q;

    logic [3:0]      col_rot;
    logic [1:0]      row_idx;
    logic [1:0]      col_idx;

    assign sample  = (dwell_cnt == DWELL_LAST);
    // 1110 -> 1101 -> 1011 -> 0111 -> 1110
    assign col_rot = {col_q[2:0], col_q[3]};

    // Next-state and column/candidate/counter updates, only at sample points.
    always_comb begin
        state_d = state;
        col_d   = col_q;
        cand_d  = cand_q;
        deb_d   = deb_cnt;
        accept  = 1'b0;
        if (sample) begin
            case (state)
                ST_SCAN: begin
                    if (rows_s == 4'hF) begin
                        col_d = col_rot;
                    end else begin
                        cand_d = rows_s;
                        if (DEBOUNCE_SCANS <= 1) begin
                            accept  = 1'b1;
                            deb_d   = '0;
                            state_d = ST_PRESSED;
                        end else begin
                            deb_d   = CW'(1);
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (rows_s == cand_q) begin
                        if (deb_cnt + CW'(1) == DEB_TARGET) begin
                            accept  = 1'b1;
                            deb_d   = '0;
                            state_d = ST_PRESSED;
                        end else begin
                            deb_d = deb_cnt + CW'(1);
                        end
                    end else begin
                        deb_d   = '0;
                        col_d   = col_rot;
                        state_d = ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    // deb_cnt now counts consecutive all-released samples
                    if (rows_s == 4'hF) begin
                        if (deb_cnt + CW'(1) == DEB_TARGET) begin
                            deb_d   = '0;
                            col_d   = col_rot;
                            state_d = ST_SCAN;
                        end else begin
                            deb_d = deb_cnt + CW'(1);
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
                default: begin
                    deb_d   = '0;
                    col_d   = 4'b1110;
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    // Key code of the press being accepted: lowest low row wins on multi-row presses.
    always_comb begin
        row_idx = 2'd3;
        if (!cand_d[0])      row_idx = 2'd0;
        else if (!cand_d[1]) row_idx = 2'd1;
        else if (!cand_d[2]) row_idx = 2'd2;
        col_idx = 2'd3;
        if (!col_q[0])       col_idx = 2'd0;
        else if (!col_q[1])  col_idx = 2'd1;
        else if (!col_q[2])  col_idx = 2'd2;
        code_d = {row_idx, col_idx};
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_SCAN;
            col_q   <= 4'b1110;
            cand_q  <= 4'hF;
            deb_cnt <= '0;
        end else begin
            state   <= state_d;
            col_q   <= col_d;
            cand_q  <= cand_d;
            deb_cnt <= deb_d;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            row_meta     <= 4'hF;
            rows_s       <= 4'hF;
            dwell_cnt    <= '0;
            key_valid_q  <= 1'b0;
            key_code_q   <= 4'h0;
            value_q      <= 16'h0000;
            data_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            row_meta <= row_in;
            rows_s   <= row_meta;
            dwell_cnt <= sample ? '0 : dwell_cnt + DW'(1);

            // key_valid and key_code appear together in the cycle after the
            // confirming sample point.
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= code_d;
            end

            if (key_valid_q) begin
                // An ack in the same cycle consumes the previous word, so the
                // new key is never an overrun in that case.
                value_q      <= {value_q[11:0], key_code_q};
                data_ready_q <= 1'b1;
                overflow_q   <= cpu.rd_ack ? 1'b0 : (overflow_q | data_ready_q);
            end else if (cpu.rd_ack) begin
                data_ready_q <= 1'b0;
                overflow_q   <= 1'b0;
            end
        end
    end

    assign col_out        = col_q;
    assign cpu.key_valid  = key_valid_q;
    assign cpu.key_code   = key_code_q;
    assign cpu.value      = value_q;
    assign cpu.data_ready = data_ready_q;
    assign cpu.overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a key-code scoreboard
`timescale 1ns/1ps

module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] press_mask = 16'h0000;
    logic        bounce_low = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int kv_count = 0;
    logic [3:0] exp_q[$];

    keypad_scanner_if kp_if ();

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .sys_clk (clk),
        .reset   (rst_n),
        .row_in  (row_in),
        .col_out (col_out),
        .cpu     (kp_if)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        logic [3:0] rows_low;
        rows_low = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (press_mask[r*4+c] && !col_out[c]) rows_low[r] = 1'b1;
            end
        end
        if (bounce_low) rows_low[1] = 1'b1;
        row_in = ~rows_low;
    end

    // Scoreboard monitor: every key_valid pops one expected code.
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if (!$onehot(~col_out)) begin
                miscompares++;
                $display("FAIL col_onehot got %b want exactly one zero", col_out);
            end
            if (kp_if.key_valid === 1'b1) begin
                kv_count++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_key_valid got code %h want no pulse", kp_if.key_code);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (kp_if.key_code !== e) begin
                        miscompares++;
                        $display("FAIL key_code got %h want %h", kp_if.key_code, e);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        kp_if.rd_ack = 1'b1;
        @(negedge clk);
        kp_if.rd_ack = 1'b0;
    endtask

    // Hold a key set for 64 cycles, then release for 40. With ack_on_valid the
    // ack is raised in exactly the key_valid cycle.
    task automatic press(input logic [15:0] mask, input logic [3:0] code, input bit ack_on_valid);
        bit acked;
        acked = 1'b0;
        exp_q.push_back(code);
        @(negedge clk);
        press_mask = mask;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            kp_if.rd_ack = 1'b0;
            if (ack_on_valid && !acked && kp_if.key_valid === 1'b1) begin
                kp_if.rd_ack = 1'b1;
                acked = 1'b1;
            end
        end
        kp_if.rd_ack = 1'b0;
        press_mask = 16'h0000;
        repeat (40) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missed_key got %0d pending want 0 (code %h)", exp_q.size(), code);
            exp_q.delete();
        end
        if (ack_on_valid) begin
            vectors++;
            if (!acked) begin
                miscompares++;
                $display("FAIL ack_align got no key_valid want one");
            end
        end
    endtask

    task automatic test_reset();
        kp_if.rd_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (col_out !== 4'b1110 || kp_if.value !== 16'h0 || kp_if.data_ready !== 1'b0 ||
            kp_if.overflow !== 1'b0 || kp_if.key_valid !== 1'b0 || kp_if.key_code !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_state got col=%b val=%h dr=%b ov=%b kv=%b kc=%h want 1110 0000 0 0 0 0",
                     col_out, kp_if.value, kp_if.data_ready, kp_if.overflow, kp_if.key_valid, kp_if.key_code);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_key();
        int kv0;
        do_reset();
        kv0 = kv_count;
        press(16'h0001 << (1*4+2), 4'h6, 1'b0);
        vectors++;
        if (kv_count - kv0 !== 1) begin
            miscompares++;
            $display("FAIL single_pulses got %0d want 1", kv_count - kv0);
        end
        vectors++;
        if (kp_if.value !== 16'h0006 || kp_if.data_ready !== 1'b1 || kp_if.key_code !== 4'h6) begin
            miscompares++;
            $display("FAIL single_word got val=%h dr=%b kc=%h want 0006 1 6",
                     kp_if.value, kp_if.data_ready, kp_if.key_code);
        end
    endtask

    task automatic test_entry();
        logic [3:0] codes [4];
        codes = '{4'h1, 4'h2, 4'h3, 4'h4};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            press(16'h0001 << codes[k], codes[k], 1'b0);
            ack_pulse();
            vectors++;
            if (kp_if.data_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL entry_ack got dr=%b want 0", kp_if.data_ready);
            end
        end
        vectors++;
        if (kp_if.value !== 16'h1234 || kp_if.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL entry_word got val=%h ov=%b want 1234 0", kp_if.value, kp_if.overflow);
        end
    endtask

    // Bounce is low 2 / high 4 cycles so no two consecutive 4-cycle samples agree.
    task automatic test_bounce();
        int kv0;
        logic [3:0] seen;
        do_reset();
        kv0 = kv_count;
        seen = 4'b0000;
        for (int p = 0; p < 7; p++) begin
            @(negedge clk);
            bounce_low = 1'b1;
            seen |= ~col_out;
            repeat (2) begin @(negedge clk); seen |= ~col_out; end
            bounce_low = 1'b0;
            repeat (3) begin @(negedge clk); seen |= ~col_out; end
        end
        repeat (40) @(negedge clk);
        vectors++;
        if (kv_count !== kv0) begin
            miscompares++;
            $display("FAIL bounce_pulses got %0d want 0", kv_count - kv0);
        end
        vectors++;
        if (seen !== 4'hF) begin
            miscompares++;
            $display("FAIL bounce_rotate got cols_seen=%b want 1111", seen);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        press(16'h0001 << 4'h5, 4'h5, 1'b0);
        press(16'h0001 << 4'hA, 4'hA, 1'b0);
        vectors++;
        if (kp_if.overflow !== 1'b1 || kp_if.data_ready !== 1'b1 || kp_if.value !== 16'h005A) begin
            miscompares++;
            $display("FAIL ovf_set got ov=%b dr=%b val=%h want 1 1 005a",
                     kp_if.overflow, kp_if.data_ready, kp_if.value);
        end
        ack_pulse();
        vectors++;
        if (kp_if.overflow !== 1'b0 || kp_if.data_ready !== 1'b0 || kp_if.value !== 16'h005A) begin
            miscompares++;
            $display("FAIL ovf_ack got ov=%b dr=%b val=%h want 0 0 005a",
                     kp_if.overflow, kp_if.data_ready, kp_if.value);
        end
        press(16'h0001 << 4'hF, 4'hF, 1'b0);
        press(16'h0001 << 4'h0, 4'h0, 1'b1);
        vectors++;
        if (kp_if.overflow !== 1'b0 || kp_if.data_ready !== 1'b1 || kp_if.value !== 16'h5AF0) begin
            miscompares++;
            $display("FAIL ovf_same_cycle got ov=%b dr=%b val=%h want 0 1 5af0",
                     kp_if.overflow, kp_if.data_ready, kp_if.value);
        end
    endtask

    task automatic test_multi_row_reset();
        int kv0;
        bit found;
        logic [15:0] m;
        m = (16'h0001 << (0*4+3)) | (16'h0001 << (2*4+3));
        do_reset();
        press(m, 4'h3, 1'b0);
        vectors++;
        if (kp_if.key_code !== 4'h3 || kp_if.value !== 16'h0003) begin
            miscompares++;
            $display("FAIL multi_row got kc=%h val=%h want 3 0003", kp_if.key_code, kp_if.value);
        end
        // Reset in the dwell after column 3 first sees the press (DEBOUNCE).
        kv0 = kv_count;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (col_out !== 4'b0111) found = 1'b1;
        end
        press_mask = m;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (col_out === 4'b0111) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL reach_col3 got col=%b want 0111 within 40 cycles", col_out);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (col_out !== 4'b1110 || kp_if.value !== 16'h0 || kp_if.data_ready !== 1'b0 ||
            kp_if.overflow !== 1'b0 || kp_if.key_valid !== 1'b0 || kp_if.key_code !== 4'h0) begin
            miscompares++;
            $display("FAIL mid_reset got col=%b val=%h dr=%b ov=%b kv=%b kc=%h want 1110 0000 0 0 0 0",
                     col_out, kp_if.value, kp_if.data_ready, kp_if.overflow, kp_if.key_valid, kp_if.key_code);
        end
        repeat (3) @(negedge clk);
        press_mask = 16'h0000;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        vectors++;
        if (kv_count !== kv0 || kp_if.data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_pulse got %0d pulses dr=%b want 0 0", kv_count - kv0, kp_if.data_ready);
        end
    endtask

    initial begin
        kp_if.rd_ack = 1'b0;
        test_reset();
        test_single_key();
        test_entry();
        test_bounce();
        test_overflow();
        test_multi_row_reset();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
